// File: rtl/ram_ctrl_pkg.sv
// Shared widths, state encoding and strobe polarity for the SRAM controller.
package ram_ctrl_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  // SRAM strobes are active-low.
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_SETUP = 3'd1,
    WR_PULSE = 3'd2,
    WR_HOLD  = 3'd3,
    RD_SETUP = 3'd4,
    RD_WAIT  = 3'd5
  } ramState;

  // A read delay of zero cycles is not physically meaningful; clamp it to one.
  function automatic int effectiveDelay(input int n);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/ram_controller_automaton.sv
// Controller FSM sequencing one write or one read per request to an
// asynchronous 16-bit SRAM. Requests are sampled whenever the FSM is idle.
module ram_controller_automaton
  import ram_ctrl_pkg::*;
#(
  parameter int CLOCK_TICKS_FOR_READ_DELAY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              opSelect,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic [DATA_W-1:0] dataIn,
  output logic [ADDR_W-1:0] addrOut,
  output logic [DATA_W-1:0] dataOut,
  output logic              chipEnable,
  output logic              outputEnable,
  output logic              writeEnable,
  output logic              lowerByte,
  output logic              upperByte
);

  localparam int N_EFF = effectiveDelay(CLOCK_TICKS_FOR_READ_DELAY);
  localparam int CNT_W = $clog2(N_EFF + 1);

  ramState              stateReg;
  ramState              stateNext;
  logic [ADDR_W-1:0]    addrReg;
  logic [DATA_W-1:0]    dataReg;
  logic [CNT_W-1:0]     waitCount;
  logic                 waitDone;

  // Last RD_WAIT cycle: read data is latched on this edge.
  assign waitDone = (waitCount == CNT_W'(1));

  assign addrOut = addrReg;
  assign dataOut = dataReg;

  // State register; reset forces IDLE so the strobes drop inactive immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Address/data capture and read-delay countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addrReg   <= '0;
      dataReg   <= '0;
      waitCount <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          addrReg <= addrIn;
          if (opSelect) begin
            dataReg <= dataIn;
          end
        end
        RD_SETUP: begin
          waitCount <= CNT_W'(N_EFF);
        end
        RD_WAIT: begin
          waitCount <= waitCount - CNT_W'(1);
          if (waitDone) begin
            dataReg <= dataIn;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic and strobe decode; strobes depend on the state register only.
  always_comb begin
    stateNext    = stateReg;
    chipEnable   = STROBE_OFF;
    outputEnable = STROBE_OFF;
    writeEnable  = STROBE_OFF;
    lowerByte    = STROBE_OFF;
    upperByte    = STROBE_OFF;
    case (stateReg)
      IDLE: begin
        stateNext = opSelect ? WR_SETUP : RD_SETUP;
      end
      WR_SETUP: begin
        chipEnable = STROBE_ON;
        lowerByte  = STROBE_ON;
        upperByte  = STROBE_ON;
        stateNext  = WR_PULSE;
      end
      WR_PULSE: begin
        chipEnable  = STROBE_ON;
        lowerByte   = STROBE_ON;
        upperByte   = STROBE_ON;
        writeEnable = STROBE_ON;
        stateNext   = WR_HOLD;
      end
      WR_HOLD: begin
        chipEnable = STROBE_ON;
        lowerByte  = STROBE_ON;
        upperByte  = STROBE_ON;
        stateNext  = IDLE;
      end
      RD_SETUP: begin
        chipEnable   = STROBE_ON;
        outputEnable = STROBE_ON;
        lowerByte    = STROBE_ON;
        upperByte    = STROBE_ON;
        stateNext    = RD_WAIT;
      end
      RD_WAIT: begin
        chipEnable   = STROBE_ON;
        outputEnable = STROBE_ON;
        lowerByte    = STROBE_ON;
        upperByte    = STROBE_ON;
        stateNext    = waitDone ? IDLE : RD_WAIT;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_controller_automaton.sv
// Directed bench for the SRAM controller: three instances (N=1, N=3, N=0)
// share the request inputs; the ones not under test are held in reset.
module tb_ram_controller_automaton;

  logic        clk = 1'b0;
  logic        rst1, rst3, rst0;
  logic        opSelect;
  logic [23:0] addrIn;
  logic [15:0] dataIn;

  logic [23:0] addr1, addr3, addr0;
  logic [15:0] data1, data3, data0;
  logic ce1, oe1, we1, lb1, ub1;
  logic ce3, oe3, we3, lb3, ub3;
  logic ce0, oe0, we0, lb0, ub0;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int weLowFirst;

  // Strobe vectors ordered {CE, OE, WE, LB, UB}
  localparam logic [4:0] S_IDLE  = 5'b11111;
  localparam logic [4:0] S_WR    = 5'b01100;
  localparam logic [4:0] S_WRPLS = 5'b01000;
  localparam logic [4:0] S_RD    = 5'b00100;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  ram_controller_automaton #(.CLOCK_TICKS_FOR_READ_DELAY(1)) dut1 (
    .clk(clk), .rst(rst1), .opSelect(opSelect), .addrIn(addrIn), .dataIn(dataIn),
    .addrOut(addr1), .dataOut(data1), .chipEnable(ce1), .outputEnable(oe1),
    .writeEnable(we1), .lowerByte(lb1), .upperByte(ub1));

  ram_controller_automaton #(.CLOCK_TICKS_FOR_READ_DELAY(3)) dut3 (
    .clk(clk), .rst(rst3), .opSelect(opSelect), .addrIn(addrIn), .dataIn(dataIn),
    .addrOut(addr3), .dataOut(data3), .chipEnable(ce3), .outputEnable(oe3),
    .writeEnable(we3), .lowerByte(lb3), .upperByte(ub3));

  ram_controller_automaton #(.CLOCK_TICKS_FOR_READ_DELAY(0)) dut0 (
    .clk(clk), .rst(rst0), .opSelect(opSelect), .addrIn(addrIn), .dataIn(dataIn),
    .addrOut(addr0), .dataOut(data0), .chipEnable(ce0), .outputEnable(oe0),
    .writeEnable(we0), .lowerByte(lb0), .upperByte(ub0));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
    $display("check %-14s cycle=%0d observed=%0h expected=%0h", tag, cycle, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // WE and OE must never be low together on any instance.
  always @(negedge clk) begin
    checks++;
    assert (!((we1 === 1'b0 && oe1 === 1'b0) || (we3 === 1'b0 && oe3 === 1'b0) ||
              (we0 === 1'b0 && oe0 === 1'b0))) else begin
      errors++;
      $error("FAIL we_oe_overlap observed=both_low expected=exclusive at cycle %0d", cycle);
    end
  end

  initial begin
    rst1 = 1'b1; rst3 = 1'b1; rst0 = 1'b1;
    opSelect = 1'b1; addrIn = 24'd100; dataIn = 16'd101;
    tick(); tick();

    // ---- Write at N=1, back-to-back with a mid-pulse data change ----
    rst1 = 1'b0;
    check("rst_strobes", {27'd0, ce1, oe1, we1, lb1, ub1}, {27'd0, S_IDLE});
    check("rst_addr", {8'd0, addr1}, 32'd0);
    check("rst_data", {16'd0, data1}, 32'd0);
    tick();
    check("wr1_setup_s", {27'd0, ce1, oe1, we1, lb1, ub1}, {27'd0, S_WR});
    check("wr1_addr", {8'd0, addr1}, 32'd100);
    check("wr1_data", {16'd0, data1}, 32'd101);
    tick();
    check("wr1_pulse_s", {27'd0, ce1, oe1, we1, lb1, ub1}, {27'd0, S_WRPLS});
    weLowFirst = cycle;
    dataIn = 16'd202;
    tick();
    check("wr1_hold_s", {27'd0, ce1, oe1, we1, lb1, ub1}, {27'd0, S_WR});
    check("wr1_hold_data", {16'd0, data1}, 32'd101);
    tick();
    check("wr1_idle_s", {27'd0, ce1, oe1, we1, lb1, ub1}, {27'd0, S_IDLE});
    check("wr1_idle_data", {16'd0, data1}, 32'd101);
    check("wr1_idle_addr", {8'd0, addr1}, 32'd100);
    tick();
    check("wr2_setup_s", {27'd0, ce1, oe1, we1, lb1, ub1}, {27'd0, S_WR});
    check("wr2_data", {16'd0, data1}, 32'd202);
    tick();
    check("wr2_pulse_s", {27'd0, ce1, oe1, we1, lb1, ub1}, {27'd0, S_WRPLS});
    check("we_spacing", cycle - weLowFirst, 32'd4);

    // ---- Asynchronous reset during WR_PULSE ----
    #1 rst1 = 1'b1;
    #1;
    check("arst_strobes", {27'd0, ce1, oe1, we1, lb1, ub1}, {27'd0, S_IDLE});
    check("arst_addr", {8'd0, addr1}, 32'd0);
    check("arst_data", {16'd0, data1}, 32'd0);
    #1 rst1 = 1'b0;
    opSelect = 1'b1; addrIn = 24'd5; dataIn = 16'h1234;

    // ---- Mixed: write 0x1234 @5, then read @5 (restart from IDLE) ----
    tick();
    check("mix_wr_setup", {27'd0, ce1, oe1, we1, lb1, ub1}, {27'd0, S_WR});
    check("mix_wr_addr", {8'd0, addr1}, 32'd5);
    check("mix_wr_data", {16'd0, data1}, 32'h1234);
    opSelect = 1'b0;
    tick();
    check("mix_wr_pulse", {27'd0, ce1, oe1, we1, lb1, ub1}, {27'd0, S_WRPLS});
    tick();
    check("mix_wr_hold", {27'd0, ce1, oe1, we1, lb1, ub1}, {27'd0, S_WR});
    tick();
    check("mix_idle", {27'd0, ce1, oe1, we1, lb1, ub1}, {27'd0, S_IDLE});
    tick();
    check("mix_rd_setup", {27'd0, ce1, oe1, we1, lb1, ub1}, {27'd0, S_RD});
    check("mix_rd_addr", {8'd0, addr1}, 32'd5);
    tick();
    check("mix_rd_wait", {27'd0, ce1, oe1, we1, lb1, ub1}, {27'd0, S_RD});
    tick();
    check("mix_rd_done", {27'd0, ce1, oe1, we1, lb1, ub1}, {27'd0, S_IDLE});
    check("mix_rd_data", {16'd0, data1}, 32'h1234);
    rst1 = 1'b1;

    // ---- Read at N=3 ----
    opSelect = 1'b0; addrIn = 24'h000ABC; dataIn = 16'hBEEF;
    rst3 = 1'b0;
    tick();
    check("rd3_setup_s", {27'd0, ce3, oe3, we3, lb3, ub3}, {27'd0, S_RD});
    check("rd3_addr", {8'd0, addr3}, 32'h000ABC);
    check("rd3_data_pre", {16'd0, data3}, 32'd0);
    tick();
    check("rd3_wait1_s", {27'd0, ce3, oe3, we3, lb3, ub3}, {27'd0, S_RD});
    tick();
    check("rd3_wait2_s", {27'd0, ce3, oe3, we3, lb3, ub3}, {27'd0, S_RD});
    tick();
    check("rd3_wait3_s", {27'd0, ce3, oe3, we3, lb3, ub3}, {27'd0, S_RD});
    check("rd3_data_mid", {16'd0, data3}, 32'd0);
    tick();
    check("rd3_idle_s", {27'd0, ce3, oe3, we3, lb3, ub3}, {27'd0, S_IDLE});
    check("rd3_data", {16'd0, data3}, 32'hBEEF);
    tick();
    check("rd3_next_s", {27'd0, ce3, oe3, we3, lb3, ub3}, {27'd0, S_RD});
    rst3 = 1'b1;

    // ---- N=0 behaves as N=1 ----
    opSelect = 1'b0; addrIn = 24'h000077; dataIn = 16'h5A5A;
    rst0 = 1'b0;
    tick();
    check("rd0_setup_s", {27'd0, ce0, oe0, we0, lb0, ub0}, {27'd0, S_RD});
    check("rd0_addr", {8'd0, addr0}, 32'h77);
    tick();
    check("rd0_wait_s", {27'd0, ce0, oe0, we0, lb0, ub0}, {27'd0, S_RD});
    tick();
    check("rd0_idle_s", {27'd0, ce0, oe0, we0, lb0, ub0}, {27'd0, S_IDLE});
    check("rd0_data", {16'd0, data0}, 32'h5A5A);
    rst0 = 1'b1;

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_controller_automaton.md
Name: ram_controller_automaton

Overview:
- Controller FSM between user logic and an external asynchronous 16-bit SRAM (24-bit address space).
- Samples a request (opSelect, addrIn, dataIn) while idle, then sequences the active-low SRAM strobes for one write or one read. Read access time is set by a parameter.
- Runs continuously: after each access it returns to IDLE and samples the next request. There is no separate start strobe.

Parameters:
- CLOCK_TICKS_FOR_READ_DELAY, default 1: number of cycles (N) the FSM waits with outputEnable asserted before latching read data. A value of 0 is treated as 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- opSelect  in  1  operation select: 1 = write, 0 = read; sampled in IDLE.
- addrIn  in  24  request address; sampled in IDLE.
- dataIn  in  16  write data (sampled in IDLE) or SRAM read data (sampled at the end of RD_WAIT); the system muxes the source.
- addrOut  out  24  registered address to the SRAM pins.
- dataOut  out  16  registered data: write data during write states, latched read data after a read.
- chipEnable  out  1  SRAM CE, active-low.
- outputEnable  out  1  SRAM OE, active-low.
- writeEnable  out  1  SRAM WE, active-low.
- lowerByte  out  1  SRAM LB, active-low.
- upperByte  out  1  SRAM UB, active-low.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset response: state goes to IDLE; addrOut = 0; dataOut = 0; chipEnable, outputEnable, writeEnable, lowerByte and upperByte are all 1 (inactive), immediately, without waiting for a clock edge.
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_WAIT.
- Strobes are decoded from the state register only, with no input-to-output combinational path.
- IDLE:
  - All strobes are 1.
  - On each edge: capture addrIn into the address register; capture opSelect; if opSelect = 1, also capture dataIn into the data register.
  - Next state is WR_SETUP if opSelect = 1, else RD_SETUP.
- WR_SETUP: addrOut and dataOut hold the captured values; CE = 0, LB = 0, UB = 0, OE = 1, WE = 1. Next state: WR_PULSE.
- WR_PULSE: as WR_SETUP but WE = 0. Next state: WR_HOLD.
- WR_HOLD: WE = 1; CE, LB and UB stay 0; address and data stay stable. Next state: IDLE.
- Write transaction length: 4 cycles including IDLE.
- RD_SETUP: addrOut = captured address; CE = 0, OE = 0, LB = 0, UB = 0, WE = 1. Load the wait counter with N. Next state: RD_WAIT.
- RD_WAIT:
  - Strobes are the same as RD_SETUP.
  - The counter decrements every cycle.
  - On the edge where the counter equals 1: dataOut <= dataIn, and next state is IDLE.
  - Read transaction length: N + 2 cycles.
- dataOut holds its last value until the next write setup or read latch.
- addrOut holds its last value while in IDLE.
- Changes to opSelect, addrIn or dataIn outside the IDLE sampling edge are ignored for the current transaction.
- WE and OE are never 0 simultaneously.
- X or Z on the inputs is captured as-is; no checking is performed.

Decomposition:
- Shared package ram_ctrl_pkg:
  - ADDR_W = 24, DATA_W = 16.
  - State enum (IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_WAIT).
  - Constant STROBE_ON = 0.
- No sub-module. The read-delay counter is an inline register sized $clog2(N+1).

Test Plan:
1. Write: N = 1; opSelect = 1, addrIn = 100, dataIn = 101 held; release reset.
   - First IDLE edge captures the request.
   - Next cycle: addrOut = 100, dataOut = 101, CE = 0, WE = 1.
   - Following cycle: WE = 0 for exactly 1 cycle.
   - Then WE = 1 with CE = 0 (hold).
   - Then all strobes return to 1.
2. Back-to-back writes: opSelect = 1 constant; dataIn changes 101 -> 202 mid-WR_PULSE.
   - The first transaction keeps dataOut = 101.
   - The second transaction shows 202.
   - WE pulses are exactly 4 cycles apart.
3. Read: N = 3; opSelect = 0, addrIn = 0x000ABC, dataIn = 0xBEEF.
   - addrOut = 0xABC.
   - OE = 0 for 4 cycles (RD_SETUP plus 3 RD_WAIT); WE stays 1.
   - dataOut = 0xBEEF after the last RD_WAIT edge.
   - Total 5 cycles before the next sample.
4. Parameter edge: N = 0 behaves identically to N = 1 (OE low for 2 cycles).
5. Reset mid-write: assert rst during WR_PULSE, asynchronously.
   - WE, CE, OE, LB, UB = 1 and addrOut = dataOut = 0 before the next clock edge.
   - After release, the FSM restarts from IDLE.
6. Mixed sequence: write 0x1234 to address 5, then read address 5 with the bench returning 0x1234 on dataIn → dataOut = 0x1234; no cycle has WE = 0 and OE = 0 simultaneously.
